// File: rtl/stream_word_packer.sv
// Packs IN_WIDTH-bit beats into LANES-lane words and queues completed words
// in a circular output FIFO; in_last closes a partial word early.
module stream_word_packer #(
   parameter int IN_WIDTH   = 8,
   parameter int LANES      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int MSB_FIRST  = 1
) (
   input  logic                              clock,
   input  logic                              clear,
   input  logic [IN_WIDTH-1:0]               in_data,
   input  logic                              in_valid,
   input  logic                              in_last,
   output logic                              in_ready,
   output logic [IN_WIDTH*LANES-1:0]         out_data,
   output logic [$clog2(LANES+1)-1:0]        out_count,
   output logic                              out_last,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

   localparam int WW = IN_WIDTH * LANES;
   localparam int CW = $clog2(LANES + 1);
   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam int KW = $clog2(LANES);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [WW-1:0] acc_q, acc_d;
   logic [KW-1:0] k_q, k_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;

   logic [WW-1:0] mem_data [FIFO_DEPTH];
   logic [CW-1:0] mem_cnt  [FIFO_DEPTH];
   logic          mem_last [FIFO_DEPTH];

   logic [KW-1:0] lane;
   logic [WW-1:0] word;
   logic          beat_fire;
   logic          complete;
   logic          pop;
   logic [CW-1:0] word_cnt;

   // Ready is taken from the registered level only, so a pop never lets
   // a beat in during the same cycle.
   assign in_ready   = (level_q < LW'(FIFO_DEPTH));
   assign out_valid  = (level_q != '0);
   assign fifo_level = level_q;
   assign out_data   = out_valid ? mem_data[rd_ptr_q] : '0;
   assign out_count  = out_valid ? mem_cnt[rd_ptr_q]  : '0;
   assign out_last   = out_valid ? mem_last[rd_ptr_q] : 1'b0;

   always_comb begin
      lane      = (MSB_FIRST != 0) ? (KW'(LANES - 1) - k_q) : k_q;
      beat_fire = in_valid && in_ready;
      complete  = beat_fire && ((k_q == KW'(LANES - 1)) || in_last);
      pop       = out_valid && out_ready;
      word_cnt  = CW'(k_q) + CW'(1);

      word = acc_q;
      word[lane*IN_WIDTH +: IN_WIDTH] = in_data;

      acc_d = acc_q;
      k_d   = k_q;
      if (complete) begin
         acc_d = '0;
         k_d   = '0;
      end else if (beat_fire) begin
         acc_d = word;
         k_d   = k_q + KW'(1);
      end

      wr_ptr_d = wr_ptr_q;
      if (complete) begin
         wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end

      rd_ptr_d = rd_ptr_q;
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end

      level_d = level_q;
      case ({complete, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         acc_q    <= '0;
         k_q      <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         acc_q    <= acc_d;
         k_q      <= k_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: outputs are masked while the FIFO is empty.
   always_ff @(posedge clock) begin
      if (!clear && complete) begin
         mem_data[wr_ptr_q] <= word;
         mem_cnt[wr_ptr_q]  <= word_cnt;
         mem_last[wr_ptr_q] <= in_last;
      end
   end

endmodule

// File: tb/tb_stream_word_packer.sv
// Directed bench for stream_word_packer: vector table plus FIFO-full,
// clear and lane-order sequences on MSB_FIRST=1 and MSB_FIRST=0 instances.
module tb_stream_word_packer;

   logic        clock = 1'b0;
   logic        clear;
   logic [7:0]  in_data;
   logic        in_valid, in_last, out_ready;

   logic        a_in_ready, a_out_last, a_out_valid;
   logic [31:0] a_out_data;
   logic [2:0]  a_out_count, a_fifo_level;
   logic        b_in_ready, b_out_last, b_out_valid;
   logic [31:0] b_out_data;
   logic [2:0]  b_out_count, b_fifo_level;

   int nvec = 0;
   int nmis = 0;

   always #5 clock = ~clock;

   stream_word_packer #(.IN_WIDTH(8), .LANES(4), .FIFO_DEPTH(4), .MSB_FIRST(1)) u_a (
      .clock(clock), .clear(clear), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(a_in_ready), .out_data(a_out_data),
      .out_count(a_out_count), .out_last(a_out_last), .out_valid(a_out_valid),
      .out_ready(out_ready), .fifo_level(a_fifo_level));

   stream_word_packer #(.IN_WIDTH(8), .LANES(4), .FIFO_DEPTH(4), .MSB_FIRST(0)) u_b (
      .clock(clock), .clear(clear), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(b_in_ready), .out_data(b_out_data),
      .out_count(b_out_count), .out_last(b_out_last), .out_valid(b_out_valid),
      .out_ready(out_ready), .fifo_level(b_fifo_level));

   typedef struct {
      logic        clr, vld, lst, ordy;
      logic [7:0]  d;
      logic        e_ov;
      logic [31:0] e_data;
      logic [2:0]  e_cnt;
      logic        e_last;
      logic [2:0]  e_lvl;
      logic        e_rdy;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic c, input logic v, input logic l, input logic r,
                       input logic [7:0] d);
      clear = c; in_valid = v; in_last = l; out_ready = r; in_data = d;
      @(posedge clock);
      #1;
   endtask

   task automatic chk_zero_a(input string nm);
      chk({nm, " ov"},   a_out_valid,  1'b0);
      chk({nm, " data"}, a_out_data,   32'h0);
      chk({nm, " cnt"},  a_out_count,  3'd0);
      chk({nm, " last"}, a_out_last,   1'b0);
      chk({nm, " lvl"},  a_fifo_level, 3'd0);
      chk({nm, " rdy"},  a_in_ready,   1'b1);
   endtask

   initial begin
      int n, widx, cyc;
      logic pre;
      logic [31:0] expw;

      clear = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = 8'h0;

      // clr vld lst ordy d | ov data cnt last lvl rdy
      tbl.push_back('{1,0,0,1,8'h00, 0,32'h0,        3'd0,0,3'd0,1});
      tbl.push_back('{0,1,0,1,8'h11, 0,32'h0,        3'd0,0,3'd0,1});
      tbl.push_back('{0,1,0,1,8'h22, 0,32'h0,        3'd0,0,3'd0,1});
      tbl.push_back('{0,1,0,1,8'h33, 0,32'h0,        3'd0,0,3'd0,1});
      tbl.push_back('{0,1,0,1,8'h44, 1,32'h11223344, 3'd4,0,3'd1,1});
      tbl.push_back('{0,0,0,1,8'h00, 0,32'h0,        3'd0,0,3'd0,1});
      tbl.push_back('{0,1,0,1,8'hAA, 0,32'h0,        3'd0,0,3'd0,1});
      tbl.push_back('{0,1,1,1,8'hBB, 1,32'hAABB0000, 3'd2,1,3'd1,1});
      tbl.push_back('{0,1,0,1,8'h01, 0,32'h0,        3'd0,0,3'd0,1});
      tbl.push_back('{0,1,0,1,8'h02, 0,32'h0,        3'd0,0,3'd0,1});
      tbl.push_back('{0,1,0,1,8'h03, 0,32'h0,        3'd0,0,3'd0,1});
      tbl.push_back('{0,1,0,1,8'h04, 1,32'h01020304, 3'd4,0,3'd1,1});
      tbl.push_back('{0,0,0,1,8'h00, 0,32'h0,        3'd0,0,3'd0,1});

      @(posedge clock); #1;
      foreach (tbl[i]) begin
         step(tbl[i].clr, tbl[i].vld, tbl[i].lst, tbl[i].ordy, tbl[i].d);
         chk($sformatf("v%0d ov", i),   a_out_valid,  tbl[i].e_ov);
         chk($sformatf("v%0d data", i), a_out_data,   tbl[i].e_data);
         chk($sformatf("v%0d cnt", i),  a_out_count,  tbl[i].e_cnt);
         chk($sformatf("v%0d last", i), a_out_last,   tbl[i].e_last);
         chk($sformatf("v%0d lvl", i),  a_fifo_level, tbl[i].e_lvl);
         chk($sformatf("v%0d rdy", i),  a_in_ready,   tbl[i].e_rdy);
      end

      // Fill FIFO with out_ready low, then drain and finish the stream.
      step(1, 0, 0, 0, 8'h0);
      n = 1; cyc = 0;
      while (n <= 16 && cyc < 40) begin
         pre = a_in_ready;
         step(0, 1, 0, 0, 8'(n));
         if (pre) n++;
         cyc++;
      end
      chk("fill accepted", n - 1, 16);
      chk("full rdy", a_in_ready, 1'b0);
      chk("full lvl", a_fifo_level, 3'd4);
      clear = 0; in_valid = 1; in_last = 0; out_ready = 1; in_data = 8'd17;
      #1;
      chk("bypass rdy", a_in_ready, 1'b0);
      chk("head word0", a_out_data, 32'h01020304);
      @(posedge clock); #1;
      chk("after pop lvl", a_fifo_level, 3'd3);
      chk("after pop rdy", a_in_ready, 1'b1);
      widx = 1; cyc = 0;
      while (widx < 5 && cyc < 60) begin
         if (a_out_valid) begin
            expw = {8'(4*widx+1), 8'(4*widx+2), 8'(4*widx+3), 8'(4*widx+4)};
            chk($sformatf("drain w%0d", widx), a_out_data, expw);
            chk($sformatf("drain c%0d", widx), a_out_count, 3'd4);
            widx++;
         end
         pre = a_in_ready && (n <= 20);
         step(0, n <= 20, 0, 1, 8'(n));
         if (pre) n++;
         cyc++;
      end
      chk("drain words", widx, 5);
      chk("drain beats", n - 1, 20);

      // Clear mid-word, then clear with two words queued.
      step(0, 0, 0, 1, 8'h0);
      step(0, 1, 0, 0, 8'hE1);
      step(0, 1, 0, 0, 8'hE2);
      step(0, 1, 0, 0, 8'hE3);
      step(1, 0, 0, 0, 8'h0);
      chk_zero_a("clr partial");
      for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 8'hC0 + 8'(i));
      chk("queued lvl", a_fifo_level, 3'd2);
      step(1, 0, 0, 0, 8'h0);
      chk_zero_a("clr queued");
      for (int i = 1; i <= 4; i++) step(0, 1, 0, 1, 8'(i));
      chk("post clr a", a_out_data, 32'h01020304);
      chk("post clr b", b_out_data, 32'h04030201);
      chk("post clr cnt", a_out_count, 3'd4);

      // Lane order on the LSB-first instance.
      step(1, 0, 0, 1, 8'h0);
      step(0, 1, 0, 1, 8'h11);
      step(0, 1, 0, 1, 8'h22);
      step(0, 1, 0, 1, 8'h33);
      step(0, 1, 0, 1, 8'h44);
      chk("lsb full data", b_out_data, 32'h44332211);
      chk("lsb full ov", b_out_valid, 1'b1);
      chk("msb full data", a_out_data, 32'h11223344);
      step(0, 1, 1, 1, 8'h5A);
      chk("lsb single data", b_out_data, 32'h0000005A);
      chk("lsb single cnt", b_out_count, 3'd1);
      chk("lsb single last", b_out_last, 1'b1);
      chk("msb single data", a_out_data, 32'h5A000000);
      step(0, 0, 0, 1, 8'h0);
      chk("lsb empty ov", b_out_valid, 1'b0);
      chk("lsb empty data", b_out_data, 32'h0);

      // in_last on the fourth beat: full count, last set.
      step(0, 1, 0, 1, 8'h0A);
      step(0, 1, 0, 1, 8'h0B);
      step(0, 1, 0, 1, 8'h0C);
      step(0, 1, 1, 1, 8'h0D);
      chk("last4 data", a_out_data, 32'h0A0B0C0D);
      chk("last4 cnt", a_out_count, 3'd4);
      chk("last4 last", a_out_last, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/stream_word_packer.md
Name: stream_word_packer

Overview:
- Parametrised successor to the fixed 8-to-32-bit shift-in producer.
- Packs a stream of IN_WIDTH-bit beats into LANES-lane output words using valid/ready handshakes on both sides.
- Supports early termination of a partial word, selectable lane order, and an output FIFO that decouples the producer side from the consumer side.
- Sits between a byte-oriented producer and a word-oriented consumer on a single clock domain.

Parameters:
- IN_WIDTH, 8: bits per input beat (lane width).
- LANES, 4: input beats per full output word; must be ≥2.
- FIFO_DEPTH, 4: output word buffer entries; must be ≥1.
- MSB_FIRST, 1: 1 = first beat in most significant lane; 0 = first beat in lane 0.

Ports:
- clock  input  1  single clock; all logic on posedge.
- clear  input  1  reset; synchronous, active-high.
- in_data  input  IN_WIDTH  input beat.
- in_valid  input  1  in_data valid.
- in_last  input  1  beat closes the current word (partial flush); qualified by in_valid.
- in_ready  output  1  packer accepts a beat this cycle.
- out_data  output  IN_WIDTH*LANES  head-of-FIFO word.
- out_count  output  $clog2(LANES+1)  number of filled lanes in out_data, 1..LANES.
- out_last  output  1  word was closed by in_last.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer takes the head word.
- fifo_level  output  $clog2(FIFO_DEPTH+1)  stored words.

Behaviour:
- Reset: clear=1 at a clock edge empties the FIFO, zeroes the partial accumulator and lane counter, and discards any partial word. Next cycle: out_valid=0, out_data=0, out_count=0, out_last=0, fifo_level=0, in_ready=1. Clear overrides all handshakes in the same cycle.
- Input handshake: a beat transfers when in_valid && in_ready.
  - in_ready = (fifo_level < FIFO_DEPTH), evaluated from registered level only.
  - No combinational dependence on out_ready and no full-FIFO bypass.
- Accumulation: lane counter k (0..LANES-1).
  - MSB_FIRST=1: beat stored in lane LANES-1-k. MSB_FIRST=0: beat stored in lane k.
  - Lane j occupies bits [j*IN_WIDTH +: IN_WIDTH].
- Word completion: occurs on the transferring beat when k==LANES-1 or in_last=1.
  - The completed word, count=k+1 and last=in_last are written to the FIFO at that edge.
  - The accumulator is zeroed and k returns to 0.
  - Unfilled lanes are zero, so partial words are left-aligned for MSB_FIRST=1 and right-aligned for MSB_FIRST=0.
  - in_last on the LANES-th beat gives count=LANES, last=1.
- Latency: out_valid rises the cycle after the completing input handshake when the FIFO was empty.
- Output: out_data, out_count and out_last reflect the FIFO head whenever out_valid=1, and are held stable until out_valid && out_ready. They are zero when empty.
- FIFO: circular buffer with read/write pointers wrapping at FIFO_DEPTH, which need not be a power of 2.
  - Simultaneous write and pop leaves fifo_level unchanged.
  - A pop while empty is ignored.
  - in_valid while in_ready=0 is ignored; the beat is held by the source.
- Partial state persists across idle cycles indefinitely. There is no timeout flush.
- Word order is strictly preserved.

Test Plan:
- Default params, out_ready=1; beats 0x11,0x22,0x33,0x44 → one cycle after 4th handshake: out_data=0x11223344, out_count=4, out_last=0, out_valid for exactly one cycle.
- Beats 0xAA, then 0xBB with in_last=1 → out_data=0xAABB0000, out_count=2, out_last=1. Next 4 beats form a fresh full word.
- out_ready=0, stream 20 beats → in_ready drops after 16th beat accepted, fifo_level=4. Raise out_ready → 4 words drain in order, then remaining 4 beats are accepted and packed.
- Full FIFO, out_ready=1 and in_valid=1 in the same cycle → in_ready=0 that cycle (no bypass); fifo_level 4→3; beat accepted next cycle.
- clear pulsed after 3 beats and again with 2 words queued → all outputs 0 next cycle, fifo_level=0. Beats 0x01..0x04 then yield 0x01020304.
- MSB_FIRST=0 instance: beats 0x11..0x44 → 0x44332211. A single beat 0x5A with in_last → 0x0000005A, out_count=1, out_last=1.
